proc_control_fsm: RTL and testbench
===================================

Name: proc_control_fsm

Overview:
- Multicycle control unit that sequences the processor's register datapath: general registers R0..R(NUM_REGS-1), accumulator A, ALU result G, and the instruction register.
- Per instruction it drives the register enables, the shared bus multiplexer select and the ALU op.
- It sits between the instruction register output and the register/bus/ALU datapath.
- At most one bus source and one destination register are active per cycle.

Parameters:
- NUM_REGS, 8, number of general registers; power of two.
- REG_ADDR_W, 3, register index width; must equal log2(NUM_REGS).
- IR_WIDTH, 9, instruction width; fields are opcode[IR_WIDTH-1 -: 3], Rx[2*REG_ADDR_W-1 -: REG_ADDR_W], Ry[REG_ADDR_W-1:0].

Ports:
- clock  in  1  rising-edge clock.
- resetn  in  1  asynchronous, active-low reset.
- run  in  1  start request, sampled in T0.
- ir_in  in  IR_WIDTH  output of the instruction register; stable from T1 until done.
- ir_load  out  1  enable for the instruction register.
- r_in  out  NUM_REGS  one-hot general register write enables.
- a_in  out  1  A register enable.
- g_in  out  1  G register enable.
- alu_op  out  2  00 add, 01 sub, 10 and.
- bus_sel  out  NUM_REGS+2  one-hot bus source: [NUM_REGS-1:0] = Rn, [NUM_REGS] = G, [NUM_REGS+1] = DIN; all-zero means the bus is idle.
- done  out  1  one-cycle pulse in the final cycle of an instruction.

Behaviour:
- Clock and reset: single clock `clock`; reset `resetn` is asynchronous and active-low.
- State register: T0, T1, T2, T3, 2 bits; only element cleared by reset, to T0.
- Output timing: all outputs are combinational decode of the state register and ir_in, and are gated to 0 while resetn = 0.
- Defaults: in every state, any output not listed is 0.
- T0:
  - ir_load = run.
  - run = 1 -> T1; otherwise stay in T0.
- Opcode 000 mv Rx,Ry:
  - T1: bus_sel = Ry, r_in[Rx] = 1, done = 1 -> T0.
- Opcode 001 mvi Rx,#D:
  - T1: bus_sel = DIN, r_in[Rx] = 1, done = 1 -> T0.
- Opcode 010 add / 011 sub:
  - T1: bus_sel = Rx, a_in = 1 -> T2.
  - T2: bus_sel = Ry, g_in = 1, alu_op = 00 (add) or 01 (sub) -> T3.
  - T3: bus_sel = G, r_in[Rx] = 1, done = 1 -> T0.
- Illegal opcodes (101, 110, 111, and 100 when the optional feature is off):
  - T1: done = 1 only; no enables, bus idle -> T0.
- Instruction latency: ir_load cycle + 1 (mv, mvi, illegal) or + 3 (ALU ops).
- Back-to-back issue:
  - run is ignored outside T0.
  - run held high gives back-to-back instructions: a T0 cycle follows each done.
- Rx = Ry: legal.
  - mv is a no-op write.
  - add doubles the register value.
  - sub yields 0.
- Invariants:
  - bus_sel is always one-hot or zero.
  - r_in is always one-hot or zero.
  - a_in, g_in and r_in are never asserted in the same cycle.
- Reset mid-instruction: state returns to T0 immediately, done is not pulsed, no further enables are issued. Register contents already written are not restored.
- ir_in is don't-care in T0.

Optional Feature:
- Macro: PROC_CTRL_AND_EN.
- Defined: opcode 100 is "and Rx,Ry", sequenced like add, with alu_op = 10 in T2.
- Undefined: opcode 100 is illegal (single T1 cycle, done only), and alu_op never takes the value 10.

Test Plan:
- Reset: resetn = 0 with run = 1 -> all outputs 0. Release resetn; at first edge with run = 1, ir_load = 1 in T0, then T1.
- mv R3,R5 (ir_in = 9'b000_011_101) -> T1: bus_sel = 10'b00_0010_0000, r_in = 8'b0000_1000, done = 1; next cycle T0.
- mvi R7,#D (ir_in = 9'b001_111_000) -> T1: bus_sel = 10'b10_0000_0000, r_in = 8'b1000_0000, done = 1.
- sub R1,R2 (9'b011_001_010) -> T1: a_in = 1, bus_sel = R1. T2: g_in = 1, alu_op = 01, bus_sel = R2. T3: bus_sel = G, r_in = 8'b0000_0010, done = 1. Total 4 cycles including fetch.
- Opcode 100 -> with PROC_CTRL_AND_EN: 4-cycle sequence with alu_op = 10. Without it: T1 done = 1 only, r_in = 0, bus_sel = 0.
- Deassert resetn in T2 of an add -> outputs 0 immediately, state T0, no done pulse. After release, the next run fetches normally.

Source files
------------

// File: rtl/proc_control_fsm.sv
// Multicycle control FSM for the register/bus/ALU datapath.
// Optional "and Rx,Ry" (opcode 100) is enabled by defining PROC_CTRL_AND_EN.
module proc_control_fsm #(
   parameter int NUM_REGS   = 8,
   parameter int REG_ADDR_W = 3,
   parameter int IR_WIDTH   = 9
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  run,
   input  logic [IR_WIDTH-1:0]   ir_in,
   output logic                  ir_load,
   output logic [NUM_REGS-1:0]   r_in,
   output logic                  a_in,
   output logic                  g_in,
   output logic [1:0]            alu_op,
   output logic [NUM_REGS+1:0]   bus_sel,
   output logic                  done
);

   localparam int BUS_W   = NUM_REGS + 2;
   localparam int BUS_G   = NUM_REGS;
   localparam int BUS_DIN = NUM_REGS + 1;

   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_MVI = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;

   typedef enum logic [1:0] {
      T0 = 2'd0,
      T1 = 2'd1,
      T2 = 2'd2,
      T3 = 2'd3
   } state_e;

   state_e state_q;
   state_e state_d;

   logic [2:0]            opcode;
   logic [REG_ADDR_W-1:0] rx;
   logic [REG_ADDR_W-1:0] ry;

   assign opcode = ir_in[IR_WIDTH-1 -: 3];
   assign rx     = ir_in[2*REG_ADDR_W-1 -: REG_ADDR_W];
   assign ry     = ir_in[REG_ADDR_W-1:0];

   logic [NUM_REGS-1:0] rx_oh;
   logic [BUS_W-1:0]    bus_rx;
   logic [BUS_W-1:0]    bus_ry;
   logic [BUS_W-1:0]    bus_g;
   logic [BUS_W-1:0]    bus_din;

   assign rx_oh   = NUM_REGS'(1) << rx;
   assign bus_rx  = BUS_W'(1) << rx;
   assign bus_ry  = BUS_W'(1) << ry;
   assign bus_g   = BUS_W'(1) << BUS_G;
   assign bus_din = BUS_W'(1) << BUS_DIN;

   // ALU-class opcodes share the three-step A / G / writeback sequence
   logic       is_alu;
   logic [1:0] alu_code;

   always_comb begin
      is_alu   = 1'b0;
      alu_code = ALU_ADD;
      unique case (opcode)
         OP_ADD: begin
            is_alu   = 1'b1;
            alu_code = ALU_ADD;
         end
         OP_SUB: begin
            is_alu   = 1'b1;
            alu_code = ALU_SUB;
         end
`ifdef PROC_CTRL_AND_EN
         OP_AND: begin
            is_alu   = 1'b1;
            alu_code = ALU_AND;
         end
`endif
         default: begin
            is_alu   = 1'b0;
            alu_code = ALU_ADD;
         end
      endcase
   end

   logic                ir_load_c;
   logic [NUM_REGS-1:0] r_in_c;
   logic                a_in_c;
   logic                g_in_c;
   logic [1:0]          alu_op_c;
   logic [BUS_W-1:0]    bus_sel_c;
   logic                done_c;

   always_comb begin
      state_d   = state_q;
      ir_load_c = 1'b0;
      r_in_c    = '0;
      a_in_c    = 1'b0;
      g_in_c    = 1'b0;
      alu_op_c  = ALU_ADD;
      bus_sel_c = '0;
      done_c    = 1'b0;
      unique case (state_q)
         T0: begin
            ir_load_c = run;
            if (run) state_d = T1;
         end
         T1: begin
            if (opcode == OP_MV) begin
               bus_sel_c = bus_ry;
               r_in_c    = rx_oh;
               done_c    = 1'b1;
               state_d   = T0;
            end else if (opcode == OP_MVI) begin
               bus_sel_c = bus_din;
               r_in_c    = rx_oh;
               done_c    = 1'b1;
               state_d   = T0;
            end else if (is_alu) begin
               bus_sel_c = bus_rx;
               a_in_c    = 1'b1;
               state_d   = T2;
            end else begin
               done_c  = 1'b1;
               state_d = T0;
            end
         end
         // ir_in is stable through an instruction, so T2/T3 only see ALU ops
         T2: begin
            if (is_alu) begin
               bus_sel_c = bus_ry;
               g_in_c    = 1'b1;
               alu_op_c  = alu_code;
               state_d   = T3;
            end else begin
               state_d = T0;
            end
         end
         T3: begin
            if (is_alu) begin
               bus_sel_c = bus_g;
               r_in_c    = rx_oh;
               done_c    = 1'b1;
            end
            state_d = T0;
         end
         default: state_d = T0;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state_q <= T0;
      else         state_q <= state_d;
   end

   always_comb begin
      ir_load = resetn & ir_load_c;
      r_in    = resetn ? r_in_c : '0;
      a_in    = resetn & a_in_c;
      g_in    = resetn & g_in_c;
      alu_op  = resetn ? alu_op_c : ALU_ADD;
      bus_sel = resetn ? bus_sel_c : '0;
      done    = resetn & done_c;
   end

endmodule

// File: tb/tb_proc_control_fsm.sv
// Randomised bench for proc_control_fsm against a micro-op table model.
// Honours PROC_CTRL_AND_EN the same way the design does.
module tb_proc_control_fsm;

   logic       clock = 1'b0;
   logic       resetn;
   logic       run;
   logic [8:0] ir_in;
   logic       ir_load;
   logic [7:0] r_in;
   logic       a_in;
   logic       g_in;
   logic [1:0] alu_op;
   logic [9:0] bus_sel;
   logic       done;

   proc_control_fsm dut (
      .clock   (clock),
      .resetn  (resetn),
      .run     (run),
      .ir_in   (ir_in),
      .ir_load (ir_load),
      .r_in    (r_in),
      .a_in    (a_in),
      .g_in    (g_in),
      .alu_op  (alu_op),
      .bus_sel (bus_sel),
      .done    (done)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic       ir_load;
      logic [7:0] r_in;
      logic       a_in;
      logic       g_in;
      logic [1:0] alu_op;
      logic [9:0] bus_sel;
      logic       done;
   } outs_t;

   outs_t obs;
   assign obs = {ir_load, r_in, a_in, g_in, alu_op, bus_sel, done};

   outs_t exp_q[$];
   int vectors = 0;
   int miscompares = 0;

   // Micro-op table: the per-cycle outputs an instruction must produce after fetch
   function automatic void expect_instr(input logic [8:0] ir);
      int    op;
      int    rx;
      int    ry;
      int    code;
      outs_t o;
      op   = int'(ir[8:6]);
      rx   = int'(ir[5:3]);
      ry   = int'(ir[2:0]);
      code = -1;
      if (op == 2) code = 0;
      if (op == 3) code = 1;
`ifdef PROC_CTRL_AND_EN
      if (op == 4) code = 2;
`endif
      o = '0;
      if (op == 0) begin
         o.bus_sel = 10'(1) << ry;
         o.r_in    = 8'(1) << rx;
         o.done    = 1'b1;
         exp_q.push_back(o);
      end else if (op == 1) begin
         o.bus_sel = 10'(1) << 9;
         o.r_in    = 8'(1) << rx;
         o.done    = 1'b1;
         exp_q.push_back(o);
      end else if (code >= 0) begin
         o.bus_sel = 10'(1) << rx;
         o.a_in    = 1'b1;
         exp_q.push_back(o);
         o         = '0;
         o.bus_sel = 10'(1) << ry;
         o.g_in    = 1'b1;
         o.alu_op  = 2'(code);
         exp_q.push_back(o);
         o         = '0;
         o.bus_sel = 10'(1) << 8;
         o.r_in    = 8'(1) << rx;
         o.done    = 1'b1;
         exp_q.push_back(o);
      end else begin
         o.done = 1'b1;
         exp_q.push_back(o);
      end
   endfunction

   task automatic check(input outs_t e, input string tag);
      vectors++;
      assert (obs === e) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
   endtask

   // Entered at posedge+1; checks on the falling edge
   task automatic cyc(input logic r, input logic [8:0] ir,
                      input outs_t e, input string tag);
      run   = r;
      ir_in = ir;
      @(negedge clock);
      check(e, tag);
      @(posedge clock);
      #1;
   endtask

   task automatic do_instr(input logic [8:0] ir, input bit noise);
      outs_t f;
      int    k;
      f         = '0;
      f.ir_load = 1'b1;
      cyc(1'b1, 9'($urandom), f, $sformatf("fetch_%03b", ir));
      expect_instr(ir);
      k = 1;
      while (exp_q.size() > 0) begin
         cyc(noise ? 1'($urandom_range(0, 1)) : 1'b0, ir,
             exp_q.pop_front(), $sformatf("T%0d_%03b", k, ir));
         k++;
      end
   endtask

   initial begin
      outs_t z;
      outs_t e;
      logic [8:0] add_ir;
      z      = '0;
      resetn = 1'b0;
      run    = 1'b1;
      ir_in  = 9'($urandom);

      @(negedge clock);
      check(z, "reset_outputs");
      @(posedge clock);
      #1;
      resetn = 1'b1;

      do_instr(9'b000_011_101, 1'b0);
      do_instr(9'b001_111_000, 1'b0);
      do_instr(9'b011_001_010, 1'b0);
      do_instr(9'b100_010_110, 1'b0);
      do_instr(9'b010_100_100, 1'b0);
      do_instr(9'b011_110_110, 1'b0);
      do_instr(9'b111_000_001, 1'b0);

      // Reset asserted in T2 of an add
      add_ir = 9'b010_010_101;
      e         = '0;
      e.ir_load = 1'b1;
      cyc(1'b1, 9'($urandom), e, "mid_fetch");
      expect_instr(add_ir);
      cyc(1'b1, add_ir, exp_q.pop_front(), "mid_T1");
      run   = 1'b1;
      ir_in = add_ir;
      #1;
      check(exp_q.pop_front(), "mid_T2");
      exp_q.delete();
      resetn = 1'b0;
      #1;
      check(z, "mid_reset_now");
      @(negedge clock);
      check(z, "mid_reset_hold");
      @(posedge clock);
      #1;
      resetn = 1'b1;
      do_instr(9'b000_001_010, 1'b0);

      for (int n = 0; n < 200; n++) begin
         int idle;
         idle = (n % 3 == 0) ? 0 : int'($urandom_range(0, 2));
         for (int i = 0; i < idle; i++)
            cyc(1'b0, 9'($urandom), z, "idle");
         do_instr(9'($urandom), 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
